// File: rtl/cv32e40p_hwloop_ctrl.sv
// Hardware-loop register file and loop-end controller.
// Holds start/end/count per loop, matches the fetch PC against loop ends and issues the branch-back to IF.
module cv32e40p_hwloop_ctrl #(
    parameter int N_HWLP      = 2,
    parameter int N_HWLP_BITS = $clog2(N_HWLP)
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic [N_HWLP_BITS-1:0] hwlp_regid_i,
    input  logic [2:0]             hwlp_we_i,
    input  logic [31:0]            hwlp_wdata_i,
    output logic [31:0]            hwlp_rdata_start_o,
    output logic [31:0]            hwlp_rdata_end_o,
    output logic [31:0]            hwlp_rdata_cnt_o,

    input  logic [31:0]            pc_i,
    input  logic                   pc_valid_i,
    input  logic                   pc_ready_i,
    output logic                   hwlp_jump_o,
    output logic [31:0]            hwlp_target_o,
    output logic [N_HWLP-1:0]      hwlp_active_o
);

    logic [31:0] start_q [N_HWLP];
    logic [31:0] start_d [N_HWLP];
    logic [31:0] end_q   [N_HWLP];
    logic [31:0] end_d   [N_HWLP];
    logic [31:0] cnt_q   [N_HWLP];
    logic [31:0] cnt_d   [N_HWLP];

    logic [N_HWLP-1:0] regid_sel;
    logic [N_HWLP-1:0] match;
    logic [N_HWLP-1:0] dec_en;
    logic              found;
    logic [31:0]       addr_wdata;

    // Out-of-range indices select no loop, so writes drop and reads fall back to 0.
    always_comb begin
        regid_sel = '0;
        for (int i = 0; i < N_HWLP; i++) begin
            regid_sel[i] = (hwlp_regid_i == i[N_HWLP_BITS-1:0]);
        end
    end

    // NOTE: combinational blocks use blocking '=' and assign every output a default first, so no latch is inferred.
    always_comb begin
        match         = '0;
        dec_en        = '0;
        found         = 1'b0;
        hwlp_jump_o   = 1'b0;
        hwlp_target_o = '0;
        for (int i = 0; i < N_HWLP; i++) begin
            match[i]  = pc_valid_i && (pc_i == end_q[i]) && (cnt_q[i] != '0);
            // Loops up to and including the one that branches back consume an iteration.
            dec_en[i] = pc_valid_i && pc_ready_i && match[i] && !found;
            if (!found && match[i] && (cnt_q[i] > 32'd1)) begin
                found         = 1'b1;
                hwlp_jump_o   = 1'b1;
                hwlp_target_o = start_q[i];
            end
        end
    end

    assign addr_wdata = {hwlp_wdata_i[31:1], 1'b0};

    // A field write overrides the decrement of the same cycle.
    always_comb begin
        for (int i = 0; i < N_HWLP; i++) begin
            start_d[i] = start_q[i];
            end_d[i]   = end_q[i];
            cnt_d[i]   = cnt_q[i];
            if (dec_en[i]) begin
                cnt_d[i] = cnt_q[i] - 32'd1;
            end
            if (regid_sel[i]) begin
                if (hwlp_we_i[0]) start_d[i] = addr_wdata;
                if (hwlp_we_i[1]) end_d[i]   = addr_wdata;
                if (hwlp_we_i[2]) cnt_d[i]   = hwlp_wdata_i;
            end
        end
    end

    // NOTE: the loop register file is small and its zero state is architecturally visible, so every entry is reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_HWLP; i++) begin
                start_q[i] <= '0;
                end_q[i]   <= '0;
                cnt_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < N_HWLP; i++) begin
                start_q[i] <= start_d[i];
                end_q[i]   <= end_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    always_comb begin
        hwlp_rdata_start_o = '0;
        hwlp_rdata_end_o   = '0;
        hwlp_rdata_cnt_o   = '0;
        hwlp_active_o      = '0;
        for (int i = 0; i < N_HWLP; i++) begin
            hwlp_active_o[i] = (cnt_q[i] != '0);
            if (regid_sel[i]) begin
                hwlp_rdata_start_o = start_q[i];
                hwlp_rdata_end_o   = end_q[i];
                hwlp_rdata_cnt_o   = cnt_q[i];
            end
        end
    end

endmodule

// File: tb/tb_cv32e40p_hwloop_ctrl.sv
// Self-checking bench for cv32e40p_hwloop_ctrl: directed loop scenarios plus random traffic against a loop model.
module tb_cv32e40p_hwloop_ctrl;

    localparam int N  = 2;
    localparam int NB = 2;  // wide enough to present out-of-range indices

    logic          clk = 1'b0;
    logic          rst;
    logic [NB-1:0] regid;
    logic [2:0]    we;
    logic [31:0]   wdata;
    logic [31:0]   rd_start, rd_end, rd_cnt;
    logic [31:0]   pc;
    logic          pc_valid, pc_ready;
    logic          jump;
    logic [31:0]   target;
    logic [N-1:0]  active;

    cv32e40p_hwloop_ctrl #(.N_HWLP(N), .N_HWLP_BITS(NB)) dut (
        .clk                (clk),
        .rst                (rst),
        .hwlp_regid_i       (regid),
        .hwlp_we_i          (we),
        .hwlp_wdata_i       (wdata),
        .hwlp_rdata_start_o (rd_start),
        .hwlp_rdata_end_o   (rd_end),
        .hwlp_rdata_cnt_o   (rd_cnt),
        .pc_i               (pc),
        .pc_valid_i         (pc_valid),
        .pc_ready_i         (pc_ready),
        .hwlp_jump_o        (jump),
        .hwlp_target_o      (target),
        .hwlp_active_o      (active)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: one start/end/count triple per loop.
    logic [31:0] m_start [N];
    logic [31:0] m_end   [N];
    logic [31:0] m_cnt   [N];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h exp=%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Innermost loop that sits at its end with iterations left to run again; -1 if none.
    function automatic int branch_loop();
        for (int l = 0; l < N; l++) begin
            if (pc_valid && pc == m_end[l] && m_cnt[l] >= 2) return l;
        end
        return -1;
    endfunction

    task automatic check_outputs();
        int          j;
        int          id;
        logic [31:0] exp_act;
        j  = branch_loop();
        id = int'(regid);
        exp_act = '0;
        for (int l = 0; l < N; l++) exp_act[l] = (m_cnt[l] != 0);
        check("jump", 32'(jump), 32'(j >= 0));
        if (j >= 0) check("target", target, m_start[j]);
        else        check("target", target, 32'h0);
        check("active", 32'(active), exp_act);
        if (id < N) begin
            check("rd_start", rd_start, m_start[id]);
            check("rd_end",   rd_end,   m_end[id]);
            check("rd_cnt",   rd_cnt,   m_cnt[id]);
        end else begin
            check("rd_start_oor", rd_start, 32'h0);
            check("rd_end_oor",   rd_end,   32'h0);
            check("rd_cnt_oor",   rd_cnt,   32'h0);
        end
    endtask

    task automatic model_edge();
        int j;
        int id;
        j  = branch_loop();
        id = int'(regid);
        if (rst) begin
            for (int l = 0; l < N; l++) begin
                m_start[l] = 0; m_end[l] = 0; m_cnt[l] = 0;
            end
        end else begin
            if (pc_valid && pc_ready) begin
                for (int l = 0; l < N; l++) begin
                    if (pc == m_end[l] && m_cnt[l] != 0 && (j < 0 || l <= j)) m_cnt[l] = m_cnt[l] - 1;
                end
            end
            if (id < N) begin
                if (we[0]) m_start[id] = wdata & ~32'h1;
                if (we[1]) m_end[id]   = wdata & ~32'h1;
                if (we[2]) m_cnt[id]   = wdata;
            end
        end
    endtask

    // Checks outputs for the current inputs, then advances one clock edge in both DUT and model.
    task automatic tick(input bit chk);
        #1;
        if (chk) check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic wr(input int id, input logic [2:0] w, input logic [31:0] d);
        regid = NB'(id); we = w; wdata = d; pc_valid = 1'b0; pc_ready = 1'b0;
        tick(1);
        we = '0;
    endtask

    task automatic present(input string tag, input logic [31:0] a, input bit rdy,
                           input bit exp_j, input logic [31:0] exp_t);
        pc = a; pc_valid = 1'b1; pc_ready = rdy; we = '0;
        #1;
        check({tag, "_jump"}, 32'(jump), 32'(exp_j));
        check({tag, "_target"}, target, exp_t);
        tick(1);
        pc_valid = 1'b0; pc_ready = 1'b0;
    endtask

    task automatic rd_cnt_chk(input string tag, input int id, input logic [31:0] exp);
        regid = NB'(id);
        #1;
        check(tag, rd_cnt, exp);
    endtask

    initial begin
        rst = 1'b1; regid = '0; we = '0; wdata = '0; pc = '0; pc_valid = 1'b0; pc_ready = 1'b0;
        tick(0);
        tick(0);
        rst = 1'b0;

        // Reset clears populated registers.
        wr(0, 3'b001, 32'h104); wr(0, 3'b010, 32'h140); wr(0, 3'b100, 32'd7);
        wr(1, 3'b100, 32'd9);
        rst = 1'b1; tick(1); rst = 1'b0;
        regid = '0; #1;
        check("rst_active", 32'(active), 32'h0);
        check("rst_rd_start", rd_start, 32'h0);
        check("rst_rd_end", rd_end, 32'h0);
        check("rst_rd_cnt", rd_cnt, 32'h0);
        check("rst_jump", 32'(jump), 32'h0);

        // Single loop, three iterations.
        wr(0, 3'b001, 32'h100); wr(0, 3'b010, 32'h10C); wr(0, 3'b100, 32'd3);
        present("it1", 32'h10C, 1'b1, 1'b1, 32'h100);
        rd_cnt_chk("it1_cnt", 0, 32'd2);
        present("it2", 32'h10C, 1'b1, 1'b1, 32'h100);
        rd_cnt_chk("it2_cnt", 0, 32'd1);
        present("it3", 32'h10C, 1'b1, 1'b0, 32'h0);
        rd_cnt_chk("it3_cnt", 0, 32'd0);
        check("it3_active", 32'(active[0]), 32'h0);

        // Stall holds the request without consuming an iteration.
        wr(0, 3'b100, 32'd2);
        for (int k = 0; k < 4; k++) present("stall", 32'h10C, 1'b0, 1'b1, 32'h100);
        rd_cnt_chk("stall_cnt", 0, 32'd2);
        present("stall_acc", 32'h10C, 1'b1, 1'b1, 32'h100);
        rd_cnt_chk("stall_acc_cnt", 0, 32'd1);

        // Nested loops sharing an end: inner exits, outer branches back.
        wr(0, 3'b010, 32'h200); wr(0, 3'b100, 32'd1);
        wr(1, 3'b001, 32'h180); wr(1, 3'b010, 32'h200); wr(1, 3'b100, 32'd5);
        present("nest", 32'h200, 1'b1, 1'b1, 32'h180);
        rd_cnt_chk("nest_cnt0", 0, 32'd0);
        rd_cnt_chk("nest_cnt1", 1, 32'd4);

        // Count write collides with a decrement on the same loop.
        wr(0, 3'b100, 32'd4);
        pc = 32'h200; pc_valid = 1'b1; pc_ready = 1'b1;
        regid = '0; we = 3'b100; wdata = 32'd10;
        tick(1);
        we = '0; pc_valid = 1'b0; pc_ready = 1'b0;
        rd_cnt_chk("coll_cnt0", 0, 32'd10);
        rd_cnt_chk("coll_cnt1", 1, 32'd4);
        wr(0, 3'b001, 32'h303);
        regid = '0; #1;
        check("start_lsb", rd_start, 32'h302);

        // Out-of-range index, then an idle loop sitting at its end.
        wr(3, 3'b100, 32'h55);
        regid = 2'd3; #1;
        check("oor_cnt", rd_cnt, 32'h0);
        check("oor_start", rd_start, 32'h0);
        rd_cnt_chk("oor_cnt0", 0, 32'd10);
        wr(0, 3'b100, 32'd0); wr(1, 3'b100, 32'd0);
        present("idle", 32'h200, 1'b1, 1'b0, 32'h0);
        rd_cnt_chk("idle_cnt0", 0, 32'd0);
        rd_cnt_chk("idle_cnt1", 1, 32'd0);

        // Random traffic against the model.
        for (int c = 0; c < 600; c++) begin
            logic [31:0] pool [8];
            pool = '{32'h100, 32'h101, 32'h200, 32'h0, 32'd3, 32'd2, 32'd1, 32'd5};
            rst   = ($urandom_range(63) == 0);
            regid = NB'($urandom_range(3));
            case ($urandom_range(7))
                4:       we = 3'b001;
                5:       we = 3'b010;
                6:       we = 3'b100;
                7:       we = 3'($urandom);
                default: we = 3'b000;
            endcase
            wdata    = ($urandom_range(7) == 0) ? $urandom : pool[$urandom_range(7)];
            case ($urandom_range(3))
                0:       pc = 32'h100;
                1:       pc = 32'h200;
                2:       pc = 32'h0;
                default: pc = $urandom;
            endcase
            pc_valid = ($urandom_range(3) != 0);
            pc_ready = $urandom_range(1);
            tick(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cv32e40p_hwloop_ctrl.md
Name: cv32e40p_hwloop_ctrl

Overview:
- Hardware-loop register file and loop-end controller for N_HWLP zero-overhead loops.
- Sits between the ID/CSR write path and the prefetch/IF stage.
- Holds start, end and count per loop; compares the current fetch PC against loop ends.
- Issues the branch-back request and target to IF, and decrements iteration counts when the loop-end instruction is accepted.

Parameters:
N_HWLP, 2, number of hardware loops; index 0 is the innermost loop and has highest priority
N_HWLP_BITS, $clog2(N_HWLP), width of the loop register index

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
hwlp_regid_i  input  N_HWLP_BITS  loop index targeted by a write or read
hwlp_we_i  input  3  write enables {count, end, start}; one-hot or zero
hwlp_wdata_i  input  32  write data
hwlp_rdata_start_o  output  32  start[hwlp_regid_i], combinational
hwlp_rdata_end_o  output  32  end[hwlp_regid_i], combinational
hwlp_rdata_cnt_o  output  32  cnt[hwlp_regid_i], combinational
pc_i  input  32  address of the instruction currently presented by IF
pc_valid_i  input  1  pc_i is valid
pc_ready_i  input  1  instruction at pc_i accepted by ID this cycle
hwlp_jump_o  output  1  IF must redirect to hwlp_target_o after the current instruction
hwlp_target_o  output  32  loop start address to fetch next
hwlp_active_o  output  N_HWLP  bit i set when cnt[i] != 0

Behaviour:
- Reset (rst=1 at clock edge): start[i], end[i] and cnt[i] all 0. Outputs: hwlp_jump_o=0, hwlp_target_o=0, hwlp_active_o=0, rdata = 0.
- Writes:
  - Register written on the edge after hwlp_we_i is asserted.
  - start/end store hwlp_wdata_i with bit 0 forced to 0.
  - cnt stores the full 32 bits.
  - Write data is visible on rdata the cycle after.
- Match: match[i] = pc_valid_i && (pc_i == end[i]) && (cnt[i] != 0). A loop with cnt==0 never matches and never decrements.
- Selection:
  - j = lowest index with match[j] && cnt[j] > 1.
  - If j exists: hwlp_jump_o=1 and hwlp_target_o=start[j]. Otherwise hwlp_jump_o=0 and hwlp_target_o=0.
  - Purely combinational from pc_i and state; zero cycles latency.
- Decrement: on an edge with pc_valid_i && pc_ready_i, every loop i with match[i] and (j does not exist or i <= j) does cnt[i] <= cnt[i]-1.
  - Inner loops that end at the same address and are on their last iteration exit to 0.
  - The loop selected by j continues.
- No decrement when pc_ready_i=0. hwlp_jump_o may still be high; IF holds the request until acceptance.
- Write and decrement to the same loop in the same cycle: the write wins for the written field. A cnt write discards the decrement.
- The counter never wraps: decrement only applies when cnt != 0.
- hwlp_active_o reflects registered cnt.
- Reset asserted mid-loop clears all state on that edge. hwlp_jump_o is 0 the following cycle.
- Invalid hwlp_regid_i (>= N_HWLP): writes are ignored, reads return 0.
- More than one bit set in hwlp_we_i: all selected fields are written with the same data.

Test Plan:
- Reset: start/end/cnt written nonzero, then rst=1 for one cycle -> hwlp_active_o=00, rdata all 0, hwlp_jump_o=0.
- Single loop, 3 iterations: loop0 start=0x100, end=0x10C, cnt=3. Present pc=0x10C accepted three times.
  - Accepts 1 and 2: hwlp_jump_o=1, target=0x100, cnt goes 2, then 1.
  - Accept 3: hwlp_jump_o=0, cnt goes 0, hwlp_active_o[0]=0.
- Stall: pc=0x10C with cnt=2 and pc_ready_i=0 for 4 cycles -> hwlp_jump_o=1 throughout, cnt stays 2. Accept -> cnt=1.
- Nested loops sharing an end: loop0 end=0x200 cnt=1, loop1 end=0x200 start=0x180 cnt=5, pc=0x200 accepted -> jump=1, target=0x180, cnt0=0, cnt1=4.
- Collision: cnt0=4 with pc at end accepted and cnt write of 10 in the same cycle -> cnt0=10. Start write of 0x303 -> reads back 0x302.
- Out-of-range and idle: regid=3 with N_HWLP=2 -> write ignored, rdata=0. pc equal to an end with cnt=0 -> jump=0, no decrement.
